mem_initiator: RTL and testbench
================================

Name: mem_initiator

Overview:
- Bus-master front end that drives the single-word memory strobe/done interface (addr, wdata, rdata, read, write, done) of the on-chip block RAM and other memory-mapped responders.
- Accepts commands from a core or DMA client over a valid/ready channel and supports bursts of 1..MAX_BURST consecutive words.
- Issues one strobe per word, waits for the responder's done pulse, and returns per-beat read data or write acknowledgements on a valid/ready response channel.
- Flags timeouts when the responder never answers.

Parameters:
- MAX_BURST, 16, maximum words per command; BLEN_W = $clog2(MAX_BURST).
- TIMEOUT, 255, cycles to wait for done before aborting a beat; 0 disables the timeout.
- TO_W, 8, timeout counter width; must satisfy TIMEOUT < 2**TO_W.

Ports:
- clk  in  1  system clock.
- res  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  initiator accepts the command this cycle.
- cmd_addr  in  32  byte start address; bits [1:0] ignored.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_len  in  BLEN_W  beats minus 1.
- cmd_wdata  in  32  write data for the current beat; sampled per beat while wr_valid.
- wr_valid  in  1  write data for the next beat available.
- wr_ready  out  1  write beat consumed.
- rsp_valid  out  1  response beat present.
- rsp_ready  in  1  client takes the response.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_last  out  1  final beat of the command.
- rsp_err  out  1  beat timed out.
- mem_addr  out  32  word-aligned byte address to the responder.
- mem_wdata  out  32  write data to the responder.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_done  in  1  responder completion pulse; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  responder read data.

Behaviour:
- Reset (asynchronous, active-high):
  - State IDLE.
  - All outputs 0, except cmd_ready = 1 once reset deasserts.
  - Beat counter and timeout counter cleared.
- Memory-side protocol:
  - mem_read and mem_write are registered and high for exactly ONE cycle per access, never both at once.
  - Holding a strobe longer would cause the responder to repeat the access.
  - Responder latency is at least 1 cycle.
  - mem_addr and mem_wdata stay stable from the strobe until done or timeout.
- States:
  - IDLE: cmd_ready = 1. On cmd_valid: latch addr, with addr[1:0] forced to 0; latch write and len; beat = 0; go to
    - LOADW if write,
    - ISSUE if read.
  - LOADW: wr_ready = 1. On wr_valid: latch cmd_wdata into mem_wdata, go to ISSUE.
  - ISSUE: assert the strobe for one cycle; clear the timeout counter; go to WAIT.
  - WAIT:
    - On mem_done: capture mem_rdata for reads, rsp_err = 0, go to RESP.
    - Else if TIMEOUT ≠ 0 and the counter reaches TIMEOUT: rsp_err = 1, rsp_rdata = 0, go to RESP.
    - Otherwise increment the counter.
  - RESP: rsp_valid = 1; rsp_last = (beat == len). Data is held until rsp_ready. When the client accepts:
    - if last or rsp_err: go to IDLE; the burst aborts on the first error;
    - else beat++, addr += 4, go to LOADW (write) or ISSUE (read).
- Address wraps modulo 2^32 with no error.
- Latency:
  - Read beat: cmd accept → strobe 1 cycle later → rsp_valid 1 cycle after done.
  - Minimum 3 cycles per beat with a 1-cycle responder.
- A mem_done arriving outside WAIT (late response after a timeout) is ignored.
- cmd_ready is 0 outside IDLE; a new command is never accepted while one is outstanding.
- Reset asserted mid-burst: immediate return to IDLE; strobes drop asynchronously; no response is emitted for the aborted beat.

Decomposition:
- Package mem_initiator_pkg holds:
  - state enum (IDLE, LOADW, ISSUE, WAIT, RESP),
  - WORD_BYTES = 4,
  - the ADDR_ALIGN mask.
- Sub-module mem_timeout_cnt: TO_W-bit counter with clear, enable and expired output.
- The FSM and datapath stay in the top module.

Test Plan:
- Single read: memory preloaded with word 0x10 = 0xDEADBEEF; cmd addr = 0x40, len = 0 → exactly one mem_read pulse at mem_addr 0x40; rsp_rdata = 0xDEADBEEF, rsp_last = 1, rsp_err = 0.
- Write burst: len = 3 at 0x100 with data 1,2,3,4 → four single-cycle mem_write pulses at 0x100/104/108/10C; four responses, rsp_last only on the 4th; readback matches.
- Backpressure: rsp_ready held low 5 cycles in RESP → rsp_rdata and rsp_last stable, no further strobe issued; the next beat proceeds after acceptance.
- Timeout: TIMEOUT = 4, responder never asserts done on a len = 2 read → rsp_err = 1, rsp_rdata = 0 on beat 0, rsp_last = 0, then IDLE; a late mem_done is ignored; the next command works.
- Alignment/wrap: cmd addr = 0xFFFF_FFFE, len = 1 → strobes at 0xFFFF_FFFC then 0x0000_0000.
- Reset mid-WAIT: assert res → mem_read/mem_write/rsp_valid = 0 and cmd_ready = 1 after release; no spurious response.

Source files
------------

// File: rtl/mem_initiator_pkg.sv
// Shared types and constants for the memory bus initiator.
package mem_initiator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOADW,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [31:0] ADDR_ALIGN = ~(WORD_BYTES - 32'd1);

endpackage

// File: rtl/mem_initiator_if.sv
// Command, write-data, response and memory strobe/done signals of the initiator.
interface mem_initiator_if #(
  parameter int BLEN_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [31:0]       cmd_addr;
  logic              cmd_write;
  logic [BLEN_W-1:0] cmd_len;
  logic [31:0]       cmd_wdata;
  logic              wr_valid;
  logic              wr_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_last;
  logic              rsp_err;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic              mem_done;
  logic [31:0]       mem_rdata;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_len, cmd_wdata, wr_valid,
           rsp_ready, mem_done, mem_rdata,
    output cmd_ready, wr_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_len, cmd_wdata, wr_valid,
           rsp_ready, mem_done, mem_rdata,
    input  cmd_ready, wr_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/mem_timeout_cnt.sv
// Per-beat watchdog: loaded with TIMEOUT on clear, counts down while enabled.
module mem_timeout_cnt #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic res,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= TO_W'(TIMEOUT);
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TO_W'(1);
    end
  end

  // A zero TIMEOUT never expires, so the initiator waits forever for done.
  assign expired = (TIMEOUT != 0) && (cnt_q == '0);

endmodule

// File: rtl/mem_initiator.sv
// Burst bus master: one registered strobe per word, waits for done, returns per-beat responses.
//
// state | meaning
// IDLE  | ready for a command
// LOADW | waiting for write data of the current beat
// ISSUE | strobe high for this single cycle
// WAIT  | waiting for done or timeout
// RESP  | response beat held until the client accepts
module mem_initiator
  import mem_initiator_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255,
  parameter int TO_W      = 8
) (
  input  logic            clk,
  input  logic            res,
  mem_initiator_if.master bus
);

  localparam int BLEN_W = $clog2(MAX_BURST);

  state_t            state, next_state;
  logic [31:0]       addr_q, wdata_q, rdata_q;
  logic              write_q, err_q, rd_q, wr_q;
  logic [BLEN_W-1:0] len_q, beat_q;
  logic              to_clear, to_en, to_expired;
  logic              last_beat, issue_write;

  mem_timeout_cnt #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .res     (res),
    .clear   (to_clear),
    .enable  (to_en),
    .expired (to_expired)
  );

  assign last_beat = (beat_q == len_q);

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    to_clear    = 1'b0;
    to_en       = 1'b0;
    issue_write = (state == IDLE) ? bus.cmd_write : write_q;
    case (state)
      IDLE:  if (bus.cmd_valid) next_state = bus.cmd_write ? LOADW : ISSUE;
      LOADW: if (bus.wr_valid) next_state = ISSUE;
      ISSUE: begin
        to_clear   = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (bus.mem_done || to_expired) next_state = RESP;
        else                            to_en      = 1'b1;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          if (last_beat || err_q) next_state = IDLE;
          else                    next_state = write_q ? LOADW : ISSUE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      // Strobes are registered off the ISSUE entry so they last exactly one cycle.
      rd_q <= (next_state == ISSUE) && (state != ISSUE) && !issue_write;
      wr_q <= (next_state == ISSUE) && (state != ISSUE) && issue_write;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr_q  <= bus.cmd_addr & ADDR_ALIGN;
            write_q <= bus.cmd_write;
            len_q   <= bus.cmd_len;
            beat_q  <= '0;
          end
        end
        LOADW: if (bus.wr_valid) wdata_q <= bus.cmd_wdata;
        WAIT: begin
          if (bus.mem_done) begin
            rdata_q <= write_q ? 32'd0 : bus.mem_rdata;
            err_q   <= 1'b0;
          end else if (to_expired) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            if (!(last_beat || err_q)) begin
              beat_q <= beat_q + BLEN_W'(1);
              addr_q <= addr_q + WORD_BYTES;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE) && !res;
  assign bus.wr_ready  = (state == LOADW);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_last  = (state == RESP) && last_beat;
  assign bus.rsp_err   = err_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_read  = rd_q;
  assign bus.mem_write = wr_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Randomized bench for mem_initiator with a word-array responder and a burst-level reference model.
module tb_mem_initiator;

  logic clk;
  logic res;

  mem_initiator_if #(.BLEN_W(4)) bus ();

  mem_initiator #(
    .MAX_BURST (16),
    .TIMEOUT   (4),
    .TO_W      (8)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] wd      [16];

  int drop_at    = -1;
  int resp_beat  = 0;
  bit late_req   = 0;
  int strobe_cnt = 0;
  bit prev_strobe = 0;
  logic [31:0] obs_addr  [$];
  logic [31:0] obs_wdata [$];
  bit          obs_isw   [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int k);
    return {a[31:2], 2'b00} + 32'(k * 4);
  endfunction

  // Strobe monitor: records every access the initiator puts on the memory side.
  always @(negedge clk) begin
    if (!res && (bus.mem_read || bus.mem_write)) begin
      chk("strobe_excl", 32'(bus.mem_read & bus.mem_write), 32'd0);
      chk("strobe_1cyc", 32'(prev_strobe), 32'd0);
      strobe_cnt++;
      obs_addr.push_back(bus.mem_addr);
      obs_wdata.push_back(bus.mem_wdata);
      obs_isw.push_back(bus.mem_write);
    end
    prev_strobe = !res && (bus.mem_read || bus.mem_write);
  end

  // Responder: random 1..3 cycle latency; beat drop_at of a command is never answered.
  initial begin
    logic [7:0]  idx;
    logic [31:0] wdat;
    bit          isw;
    int          lat;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (late_req) begin
        late_req = 0;
        @(posedge clk); #1;
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        bus.mem_done  = 1'b0;
        bus.mem_rdata = 32'd0;
      end else if (!res && (bus.mem_read || bus.mem_write)) begin
        idx  = bus.mem_addr[9:2];
        isw  = bus.mem_write;
        wdat = bus.mem_wdata;
        if (resp_beat != drop_at) begin
          lat = $urandom_range(1, 3);
          @(posedge clk); #1;
          repeat (lat - 1) begin
            @(posedge clk); #1;
          end
          bus.mem_done = 1'b1;
          if (isw) mem[idx] = wdat;
          else     bus.mem_rdata = mem[idx];
          @(posedge clk); #1;
          bus.mem_done  = 1'b0;
          bus.mem_rdata = 32'd0;
        end
        resp_beat++;
      end
    end
  end

  task automatic run_cmd(input logic [31:0] a, input bit w, input int len, input int drop, input int bp);
    int nb, to;
    logic [31:0] ba, exp_rd;
    bit exp_err;
    int sc;
    logic [31:0] hold_rd;
    logic hold_last;
    nb = (drop >= 0) ? drop + 1 : len + 1;
    obs_addr.delete();
    obs_wdata.delete();
    obs_isw.delete();
    drop_at   = drop;
    resp_beat = 0;
    @(negedge clk);
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_write = w;
    bus.cmd_len   = 4'(len);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
    for (int k = 0; k < nb; k++) begin
      ba = beat_addr(a, k);
      if (w) begin
        bus.wr_valid  = 1'b1;
        bus.cmd_wdata = wd[k];
        to = 0;
        while (!bus.wr_ready && to < 50) begin
          @(negedge clk);
          to++;
        end
        chk("wr_ready_wait", 32'(to < 50), 32'd1);
        @(negedge clk);
        bus.wr_valid = 1'b0;
      end
      to = 0;
      while (!bus.rsp_valid && to < 50) begin
        @(negedge clk);
        to++;
      end
      chk("rsp_wait", 32'(to < 50), 32'd1);
      exp_err = (k == drop);
      exp_rd  = (exp_err || w) ? 32'd0 : ref_mem[ba[9:2]];
      chk("rsp_rdata", bus.rsp_rdata, exp_rd);
      chk("rsp_last", 32'(bus.rsp_last), 32'(k == len));
      chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
      if (w && !exp_err) ref_mem[ba[9:2]] = wd[k];
      if (bp > 0) begin
        sc        = strobe_cnt;
        hold_rd   = bus.rsp_rdata;
        hold_last = bus.rsp_last;
        repeat (bp) @(negedge clk);
        chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_rdata", bus.rsp_rdata, hold_rd);
        chk("bp_last", 32'(bus.rsp_last), 32'(hold_last));
        chk("bp_no_strobe", 32'(strobe_cnt), 32'(sc));
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
    end
    chk("strobe_count", 32'(obs_addr.size()), 32'(nb));
    for (int k = 0; k < nb && k < obs_addr.size(); k++) begin
      chk("strobe_addr", obs_addr[k], beat_addr(a, k));
      chk("strobe_kind", 32'(obs_isw[k]), 32'(w));
      if (w) chk("strobe_wdata", obs_wdata[k], wd[k]);
    end
    chk("cmd_ready_done", 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    bit seen;
    int to;
    int len, drop;
    res           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 32'd0;
    bus.cmd_write = 1'b0;
    bus.cmd_len   = 4'd0;
    bus.cmd_wdata = 32'd0;
    bus.wr_valid  = 1'b0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[8'h10]     = 32'hDEAD_BEEF;
    ref_mem[8'h10] = 32'hDEAD_BEEF;

    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    res = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Single read of the preloaded word.
    run_cmd(32'h40, 1'b0, 0, -1, 0);

    // Four-beat write burst, then read it back.
    for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
    run_cmd(32'h100, 1'b1, 3, -1, 0);
    run_cmd(32'h100, 1'b0, 3, -1, 0);

    // Response backpressure.
    run_cmd(32'h80, 1'b0, 1, -1, 5);

    // Timeout on the first beat, late done ignored, next command still works.
    run_cmd(32'h20, 1'b0, 2, 0, 0);
    late_req = 1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= bus.rsp_valid | bus.mem_read | bus.mem_write | !bus.cmd_ready;
    end
    chk("late_done_ignored", 32'(seen), 32'd0);
    run_cmd(32'h24, 1'b0, 0, -1, 0);

    // Unaligned start that wraps past the top of the address space.
    run_cmd(32'hFFFF_FFFE, 1'b0, 1, -1, 0);

    // Reset while a beat is outstanding.
    drop_at   = 0;
    resp_beat = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h200;
    bus.cmd_write = 1'b0;
    bus.cmd_len   = 4'd2;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    to = 0;
    while (!bus.mem_read && to < 20) begin
      @(negedge clk);
      to++;
    end
    chk("rst_mid_strobe_seen", 32'(to < 20), 32'd1);
    res = 1'b1;
    #1;
    chk("rst_mid_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mid_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    chk("rst_mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen |= bus.rsp_valid | bus.mem_read | bus.mem_write;
    end
    chk("rst_mid_quiet", 32'(seen), 32'd0);
    run_cmd(32'h200, 1'b0, 2, -1, 0);

    // Randomized bursts with occasional timeouts and backpressure.
    for (int n = 0; n < 40; n++) begin
      len  = $urandom_range(0, 7);
      drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1;
      for (int i = 0; i < 16; i++) wd[i] = $urandom;
      run_cmd($urandom, 1'($urandom_range(0, 1)), len, drop, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
